// File: rtl/cp0_ext_if.sv
// Pipeline <-> coprocessor-0 signal bundle. The M stage drives the master side.
interface cp0_ext_if #(
    parameter int NUM_HWINT = 6
);
    logic [4:0]           mf;
    logic [4:0]           mt;
    logic [31:0]          Din;
    logic                 We;
    logic [31:0]          PC;
    logic                 BD_in;
    logic                 ExcReq;
    logic [4:0]           ExcCode_in;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic                 IntReq;
    logic                 ExcEntry;
    logic [31:0]          EPC;
    logic [31:0]          Dout;

    modport master (
        output mf, mt, Din, We, PC, BD_in, ExcReq, ExcCode_in, HWInt, EXLClr,
        input  IntReq, ExcEntry, EPC, Dout
    );

    modport slave (
        input  mf, mt, Din, We, PC, BD_in, ExcReq, ExcCode_in, HWInt, EXLClr,
        output IntReq, ExcEntry, EPC, Dout
    );
endinterface

// File: rtl/cp0_ext.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt-vs-exception arbitration and
// exception entry bookkeeping for the M stage.
module cp0_ext #(
    parameter int          NUM_HWINT = 6,
    parameter logic [31:0] PRID_VAL  = 32'h0000_5037,
    parameter bit          EPC_ALIGN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    cp0_ext_if.slave  bus
);

    logic [NUM_HWINT-1:0] im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic [NUM_HWINT-1:0] ip_q, ip_d;
    logic [4:0]           code_q, code_d;
    logic [31:0]          epc_q, epc_d;

    logic                 int_req_s;
    logic                 exc_entry_s;
    logic                 wr_sr_s;
    logic                 wr_epc_s;
    logic [31:0]          pc_adj_s;
    logic [31:0]          epc_entry_s;
    logic [31:0]          sr_word_s;
    logic [31:0]          cause_word_s;
    logic [31:0]          dout_s;

    assign int_req_s   = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_entry_s = int_req_s | (bus.ExcReq & ~exl_q);
    assign wr_sr_s     = bus.We & (bus.mt == 5'd12);
    assign wr_epc_s    = bus.We & (bus.mt == 5'd14);

    // Entry PC: a delay-slot instruction restarts at its branch.
    always_comb begin
        pc_adj_s    = bus.BD_in ? (bus.PC - 32'd4) : bus.PC;
        epc_entry_s = pc_adj_s;
        if (EPC_ALIGN) begin
            epc_entry_s = {pc_adj_s[31:2], 2'b00};
        end else begin
            epc_entry_s = pc_adj_s;
        end
    end

    // Next-state: entry beats eret, which beats mtc0.
    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;
        ip_d   = bus.HWInt;
        if (exc_entry_s) begin
            exl_d  = 1'b1;
            bd_d   = bus.BD_in;
            code_d = int_req_s ? 5'd0 : bus.ExcCode_in;
            epc_d  = epc_entry_s;
        end else begin
            if (wr_sr_s) begin
                im_d = bus.Din[10 +: NUM_HWINT];
                ie_d = bus.Din[0];
            end else begin
                im_d = im_q;
                ie_d = ie_q;
            end
            if (bus.EXLClr) begin
                exl_d = 1'b0;
            end else if (wr_sr_s) begin
                exl_d = bus.Din[1];
            end else begin
                exl_d = exl_q;
            end
            if (wr_epc_s) begin
                epc_d = bus.Din;
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q   <= {NUM_HWINT{1'b0}};
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= {NUM_HWINT{1'b0}};
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    // Register images and mfc0 read mux.
    always_comb begin
        sr_word_s                     = 32'd0;
        sr_word_s[10 +: NUM_HWINT]    = im_q;
        sr_word_s[1]                  = exl_q;
        sr_word_s[0]                  = ie_q;
        cause_word_s                  = 32'd0;
        cause_word_s[31]              = bd_q;
        cause_word_s[10 +: NUM_HWINT] = ip_q;
        cause_word_s[6:2]             = code_q;
        case (bus.mf)
            5'd12:   dout_s = sr_word_s;
            5'd13:   dout_s = cause_word_s;
            5'd14:   dout_s = epc_q;
            5'd15:   dout_s = PRID_VAL;
            default: dout_s = 32'd0;
        endcase
    end

    assign bus.IntReq   = int_req_s;
    assign bus.ExcEntry = exc_entry_s;
    assign bus.EPC      = epc_q;
    assign bus.Dout     = dout_s;

endmodule

// File: tb/tb_cp0_ext.sv
// Table-driven bench for cp0_ext with a scoreboard queue of expected outputs.
module tb_cp0_ext;

    logic clk;
    logic rst;

    cp0_ext_if #(.NUM_HWINT(6)) bus ();

    cp0_ext #(
        .NUM_HWINT(6),
        .PRID_VAL (32'h0000_5037),
        .EPC_ALIGN(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  mt;
        logic [31:0] din;
        logic [5:0]  hw;
        logic        exc;
        logic [4:0]  code;
        logic        bd;
        logic [31:0] pc;
        logic        clr;
        logic [4:0]  mf;
        logic        e_int;
        logic        e_ent;
        logic [31:0] e_dout;
        logic [31:0] e_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic        e_int;
        logic        e_ent;
        logic [31:0] e_dout;
        logic [31:0] e_epc;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks;
    int   failures;

    task automatic v(input logic we, input logic [4:0] mt, input logic [31:0] din,
                     input logic [5:0] hw, input logic exc, input logic [4:0] code,
                     input logic bd, input logic [31:0] pc, input logic clr,
                     input logic [4:0] mf, input logic e_int, input logic e_ent,
                     input logic [31:0] e_dout, input logic [31:0] e_epc);
        vec_t t;
        t = '{we, mt, din, hw, exc, code, bd, pc, clr, mf, e_int, e_ent, e_dout, e_epc};
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.We         = t.we;
        bus.mt         = t.mt;
        bus.Din        = t.din;
        bus.HWInt      = t.hw;
        bus.ExcReq     = t.exc;
        bus.ExcCode_in = t.code;
        bus.BD_in      = t.bd;
        bus.PC         = t.pc;
        bus.EXLClr     = t.clr;
        bus.mf         = t.mf;
    endtask

    task automatic idle(input logic [4:0] mf);
        vec_t t;
        t = '{1'b0, 5'd0, 32'd0, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, mf,
              1'b0, 1'b0, 32'd0, 32'd0};
        drive(t);
    endtask

    initial begin
        exp_t e;
        vec_t t;
        checks   = 0;
        failures = 0;

        //  we mt     din            hw     exc code   bd pc             clr mf     int ent dout           epc
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd12, 0, 0, 32'h0000_0000, 32'h0);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h0000_0000, 32'h0);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd14, 0, 0, 32'h0000_0000, 32'h0);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd15, 0, 0, 32'h0000_5037, 32'h0);
        v(1, 5'd12, 32'h0000_0401, 6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd12, 0, 0, 32'h0000_0000, 32'h0);
        v(0, 5'd0,  32'h0,         6'd1, 0, 5'd0,  0, 32'h0000_3010,0, 5'd12, 1, 1, 32'h0000_0401, 32'h0);
        v(0, 5'd0,  32'h0,         6'd1, 0, 5'd0,  0, 32'h0,        0, 5'd12, 0, 0, 32'h0000_0403, 32'h0000_3010);
        v(0, 5'd0,  32'h0,         6'd1, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h0000_0400, 32'h0000_3010);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        1, 5'd13, 0, 0, 32'h0000_0400, 32'h0000_3010);
        v(0, 5'd0,  32'h0,         6'd0, 1, 5'd4,  1, 32'h0000_3020,0, 5'd12, 0, 1, 32'h0000_0401, 32'h0000_3010);
        v(0, 5'd0,  32'h0,         6'd0, 1, 5'd7,  0, 32'h0000_5000,0, 5'd13, 0, 0, 32'h8000_0010, 32'h0000_301C);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        1, 5'd14, 0, 0, 32'h0000_301C, 32'h0000_301C);
        v(0, 5'd0,  32'h0,         6'd1, 1, 5'd10, 0, 32'h0000_3040,0, 5'd13, 1, 1, 32'h8000_0010, 32'h0000_301C);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h0000_0400, 32'h0000_3040);
        v(1, 5'd12, 32'h0000_0003, 6'd0, 0, 5'd0,  0, 32'h0,        1, 5'd12, 0, 0, 32'h0000_0403, 32'h0000_3040);
        v(1, 5'd12, 32'h0000_0401, 6'd0, 1, 5'd8,  0, 32'h0000_3050,1, 5'd12, 0, 1, 32'h0000_0001, 32'h0000_3040);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd12, 0, 0, 32'h0000_0003, 32'h0000_3050);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h0000_0020, 32'h0000_3050);
        v(1, 5'd14, 32'h0000_4002, 6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd14, 0, 0, 32'h0000_3050, 32'h0000_3050);
        v(1, 5'd13, 32'hFFFF_FFFF, 6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd14, 0, 0, 32'h0000_4002, 32'h0000_4002);
        v(1, 5'd15, 32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h0000_0020, 32'h0000_4002);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd15, 0, 0, 32'h0000_5037, 32'h0000_4002);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd3,  0, 0, 32'h0000_0000, 32'h0000_4002);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        1, 5'd12, 0, 0, 32'h0000_0003, 32'h0000_4002);
        v(0, 5'd0,  32'h0,         6'd0, 1, 5'd12, 1, 32'h0000_3067,0, 5'd14, 0, 1, 32'h0000_4002, 32'h0000_4002);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd14, 0, 0, 32'h0000_3060, 32'h0000_3060);
        v(0, 5'd0,  32'h0,         6'd0, 0, 5'd0,  0, 32'h0,        0, 5'd13, 0, 0, 32'h8000_0030, 32'h0000_3060);

        rst = 1'b1;
        idle(5'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            e = '{i, tbl[i].e_int, tbl[i].e_ent, tbl[i].e_dout, tbl[i].e_epc};
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty vec=%0d", i);
            end else begin
                e = sb.pop_front();
                check("IntReq",   e.idx, {31'd0, bus.IntReq},   {31'd0, e.e_int});
                check("ExcEntry", e.idx, {31'd0, bus.ExcEntry}, {31'd0, e.e_ent});
                check("Dout",     e.idx, bus.Dout,              e.e_dout);
                check("EPC",      e.idx, bus.EPC,               e.e_epc);
            end
        end

        // Asynchronous reset mid-cycle clears EPC without a clock edge.
        @(posedge clk);
        #1;
        t = '{1'b1, 5'd14, 32'h0000_4002, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd14,
              1'b0, 1'b0, 32'd0, 32'd0};
        drive(t);
        @(posedge clk);
        #1 idle(5'd14);
        @(negedge clk);
        check("mtc0_epc_read", 100, bus.Dout, 32'h0000_4002);
        #2 rst = 1'b1;
        #1;
        check("async_rst_epc",  101, bus.EPC,  32'h0000_0000);
        check("async_rst_dout", 102, bus.Dout, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        // Reset during a pending interrupt entry loses the entry.
        @(posedge clk);
        #1;
        t = '{1'b1, 5'd12, 32'h0000_0401, 6'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0, 5'd12,
              1'b0, 1'b0, 32'd0, 32'd0};
        drive(t);
        @(posedge clk);
        #1 idle(5'd12);
        bus.HWInt = 6'd1;
        bus.PC    = 32'h0000_7000;
        @(negedge clk);
        check("pre_rst_intreq", 103, {31'd0, bus.IntReq}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_intreq", 104, {31'd0, bus.IntReq}, 32'd0);
        rst = 1'b0;
        bus.HWInt = 6'd0;
        @(negedge clk);
        check("rst_sr",  105, bus.Dout, 32'h0000_0000);
        check("rst_epc", 106, bus.EPC,  32'h0000_0000);
        bus.mf = 5'd15;
        #1;
        check("prid", 107, bus.Dout, 32'h0000_5037);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
